// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper: FSM state encoding and
// code/ID widths for a 3-input gate under test.
package tt_sweep_pkg;

  localparam int unsigned IDX_W     = 3;
  localparam int unsigned NUM_CODES = 8;
  localparam int unsigned TT_ID_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    COMMIT,
    DONE
  } state_t;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
// Only built when TT_SWEEP_SYNC_EN is defined.
`ifdef TT_SWEEP_SYNC_EN
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`endif

// File: rtl/truth_table_sweeper.sv
// Sweeps {in1,in2,in3} over all 8 codes, majority-samples the gate output and
// builds/compares the truth-table ID. TT_SWEEP_SYNC_EN adds a 2-flop input synchronizer.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 16,
  parameter int unsigned        SAMPLES       = 8,
  parameter logic [TT_ID_W-1:0] EXPECTED      = 8'hB1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [IDX_W-1:0]   in_vec,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic [TT_ID_W-1:0] measured,
  output logic               pass,
  output logic [TT_ID_W-1:0] mismatch
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SMP_W = $clog2(SAMPLES + 1);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(SAMPLES - 1);
  localparam logic [SMP_W:0]   SAMPLES_X   = (SMP_W + 1)'(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CODES - 1);

  state_t state_q, state_d;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   in_vec_q, in_vec_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [SMP_W-1:0]   ones_q, ones_d;
  logic [TT_ID_W-1:0] measured_q, measured_d;
  logic [TT_ID_W-1:0] mismatch_q, mismatch_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;

  logic dut_s;
  logic busy_c;
  logic start_acc;
  logic row_bit;

`ifdef TT_SWEEP_SYNC_EN
  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (dut_s)
  );
`else
  assign dut_s = dut_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start && !abort) state_d = APPLY;
      APPLY:      state_d = SETTLE;
      SETTLE:     if (set_cnt_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:     if (smp_cnt_q == SAMPLE_LAST) state_d = COMMIT;
      COMMIT:     state_d = (idx_q == LAST_IDX) ? DONE : APPLY;
      default:    state_d = IDLE;
    endcase
    if (abort && busy_c) state_d = IDLE;
  end

  // Strict majority: 2*ones > SAMPLES, so an exact tie reads as 0.
  assign row_bit   = ({ones_q, 1'b0} > SAMPLES_X);
  assign busy_c    = (state_q inside {APPLY, SETTLE, SAMPLE, COMMIT});
  assign start_acc = (state_q inside {IDLE, DONE}) && start && !abort;

  always_comb begin
    idx_d      = idx_q;
    in_vec_d   = in_vec_q;
    set_cnt_d  = set_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    ones_d     = ones_q;
    measured_d = measured_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          idx_d      = '0;
          measured_d = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
        end
      end
      APPLY: begin
        in_vec_d  = idx_q;
        set_cnt_d = '0;
        smp_cnt_d = '0;
        ones_d    = '0;
      end
      SETTLE: set_cnt_d = set_cnt_q + 1'b1;
      SAMPLE: begin
        smp_cnt_d = smp_cnt_q + 1'b1;
        ones_d    = ones_q + SMP_W'(dut_s);
      end
      COMMIT: begin
        // For a 3-bit index, ~idx == 7-idx: code 0 lands in the MSB.
        measured_d[~idx_q] = row_bit;
        if (idx_q == LAST_IDX) begin
          done_d     = 1'b1;
          pass_d     = (measured_d == EXPECTED);
          mismatch_d = measured_d ^ EXPECTED;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (abort && busy_c) begin
      in_vec_d   = '0;
      measured_d = measured_q;
      mismatch_d = '0;
      pass_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      in_vec_q   <= '0;
      set_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      ones_q     <= '0;
      measured_q <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      in_vec_q   <= in_vec_d;
      set_cnt_q  <= set_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      ones_q     <= ones_d;
      measured_q <= measured_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

  assign in_vec   = in_vec_q;
  assign busy     = busy_c;
  assign done     = done_q;
  assign measured = measured_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a 0xB1 gate model plus stuck/glitch controls.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [2:0] in_vec;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] measured;
  logic       pass;
  logic [7:0] mismatch;

  logic       stuck_en  = 1'b0;
  logic       stuck_val = 1'b0;
  logic       glitch    = 1'b0;
  logic [7:0] golden    = 8'hB1;
  logic [2:0] gidx;

  int n_checks = 0;
  int n_pass   = 0;
  int edges;
  logic seen;

  truth_table_sweeper dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_vec   (in_vec),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .measured (measured),
    .pass     (pass),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  assign gidx    = 3'd7 - in_vec;
  assign dut_out = stuck_en ? stuck_val : (golden[gidx] & ~glitch);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Start is seen by the first posedge; returns #1 after that accepting edge.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output logic hit);
    n   = 0;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1 n++;
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_vec", in_vec, 0);
    chk("rst_measured", measured, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mismatch", mismatch, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: golden gate, latency and result
    do_start();
    chk("t1_busy_after_start", busy, 1);
    wait_done(400, edges, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_latency", edges + 1, 209);
    chk("t1_measured", measured, 8'hB1);
    chk("t1_pass", pass, 1);
    chk("t1_mismatch", mismatch, 8'h00);
    chk("t1_busy_in_done", busy, 0);
    chk("t1_in_vec_held", in_vec, 7);
    @(posedge clk);
    #1 chk("t1_done_one_cycle", done, 0);
    chk("t1_pass_held", pass, 1);

    // 2: stuck-at outputs
    stuck_en = 1'b1; stuck_val = 1'b0;
    do_start();
    wait_done(400, edges, seen);
    chk("t2s0_done_seen", seen, 1);
    chk("t2s0_measured", measured, 8'h00);
    chk("t2s0_pass", pass, 0);
    chk("t2s0_mismatch", mismatch, 8'hB1);
    stuck_val = 1'b1;
    do_start();
    wait_done(400, edges, seen);
    chk("t2s1_done_seen", seen, 1);
    chk("t2s1_measured", measured, 8'hFF);
    chk("t2s1_pass", pass, 0);
    chk("t2s1_mismatch", mismatch, 8'h4E);
    stuck_en = 1'b0;

    // 3: glitches in code 3; its samples are taken in the cycles starting at accept+95..+102
    do_start();
    repeat (95) @(posedge clk);
    #1 glitch = 1'b1;
    repeat (3) @(posedge clk);
    #1 glitch = 1'b0;
    wait_done(400, edges, seen);
    chk("t3g3_done_seen", seen, 1);
    chk("t3g3_measured", measured, 8'hB1);
    chk("t3g3_pass", pass, 1);
    do_start();
    repeat (95) @(posedge clk);
    #1 glitch = 1'b1;
    repeat (4) @(posedge clk);
    #1 glitch = 1'b0;
    wait_done(400, edges, seen);
    chk("t3g4_done_seen", seen, 1);
    chk("t3g4_measured", measured, 8'hA1);
    chk("t3g4_pass", pass, 0);
    chk("t3g4_mismatch", mismatch, 8'h10);

    // 4: abort during code 4 SAMPLE (cycles starting accept+121..+128)
    do_start();
    repeat (122) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_in_vec", in_vec, 0);
    chk("t4_pass", pass, 0);
    chk("t4_partial_rows", measured, 8'hB0);
    wait_done(300, edges, seen);
    chk("t4_no_done", seen, 0);
    chk("t4_still_idle", busy, 0);
    do_start();
    wait_done(400, edges, seen);
    chk("t4_rerun_done_seen", seen, 1);
    chk("t4_rerun_measured", measured, 8'hB1);
    chk("t4_rerun_pass", pass, 1);

    // 5: start pulsed mid-sweep must not restart or shift timing
    do_start();
    repeat (50) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(400, edges, seen);
    chk("t5_done_seen", seen, 1);
    chk("t5_latency", edges + 52, 209);
    chk("t5_measured", measured, 8'hB1);

    // 6: async reset during code 1 SETTLE
    do_start();
    repeat (30) @(posedge clk);
    #1 chk("t6_pre_in_vec", in_vec, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_in_vec", in_vec, 0);
    chk("t6_measured", measured, 0);
    chk("t6_pass", pass, 0);
    chk("t6_mismatch", mismatch, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_done(60, edges, seen);
    chk("t6_no_resume_done", seen, 0);
    chk("t6_no_resume_busy", busy, 0);

    // 5b: start and abort together in IDLE -> abort wins
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    @(posedge clk);
    #1 chk("t5b_busy", busy, 0);
    chk("t5b_in_vec", in_vec, 0);

    do_start();
    wait_done(400, edges, seen);
    chk("final_done_seen", seen, 1);
    chk("final_latency", edges + 1, 209);
    chk("final_pass", pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
